control_teclado: RTL
====================

// Module: control_teclado
// PURPOSE
//   Control stage for the 4-key keypad. Synchronises and debounces the raw key
//   lines and resolves one key per press. Drives the one-hot load1..load4 pulses
//   and the rtecla clear pulse into the keypad datapath, which latches the key
//   code 1..4 on negedge clk.
//   A consumer acknowledges the key with tecla_leida. No new press is accepted
//   until that acknowledge arrives.
// PARAMETERS
//   DEB_CYCLES  500000  clk cycles a level must be stable to count as valid (10 ms @ 50 MHz)
//   CNT_W       20      debounce counter width; must satisfy 2**CNT_W > DEB_CYCLES
// PORTS
//   clk          in   1  system clock; all state changes on posedge
//   reset        in   1  synchronous, active-high reset
//   teclas       in   4  raw key lines, active-high, asynchronous to clk; bit0 = key 1
//   tecla_leida  in   1  consumer has read the key code (level, sampled on posedge)
//   load1        out  1  1-cycle pulse: key 1 accepted
//   load2        out  1  1-cycle pulse: key 2 accepted
//   load3        out  1  1-cycle pulse: key 3 accepted
//   load4        out  1  1-cycle pulse: key 4 accepted
//   rtecla       out  1  1-cycle pulse: clear the latched key code
//   ocupado      out  1  high from the cycle after LOAD until the cycle rtecla pulses
// BEHAVIOUR
//   - Synchroniser: teclas passes through a 2-FF synchroniser, giving key_sync.
//     key_sync lags a pin change by 2 cycles.
//   - FSM states: IDLE, DEBOUNCE, LOAD, WAIT_REL, REL_DEB. All outputs are decoded
//     from registered state/flags, so they are stable at negedge clk.
//   - IDLE: if key_sync != 0 and ocupado == 0:
//     - capture snap <= key_sync;
//     - capture sel <= lowest set bit of key_sync (priority: key1 > key2 > key3 > key4);
//     - set cnt <= 0; go to DEBOUNCE.
//     Otherwise stay in IDLE.
//   - DEBOUNCE: if key_sync != snap, go to IDLE (glitch rejected, no output).
//     Else if cnt == DEB_CYCLES-1, go to LOAD. Else cnt <= cnt+1.
//   - LOAD: exactly one cycle. load<sel> = 1; all other loads stay 0.
//     Sets ocupado (visible the next cycle); go to WAIT_REL.
//   - WAIT_REL: when key_sync == 0, set cnt <= 0 and go to REL_DEB.
//     A held key never produces a second load (no auto-repeat).
//   - REL_DEB: if key_sync != 0, go to WAIT_REL.
//     Else if cnt == DEB_CYCLES-1, go to IDLE. Else cnt <= cnt+1.
//   - Latency: a clean press asserts loadN in the cycle 2+1+DEB_CYCLES posedges
//     after the pin rises (sync + IDLE + debounce).
//   - Acknowledge: if tecla_leida == 1 and ocupado == 1 at a posedge, then in the
//     next cycle rtecla = 1 for exactly one cycle and ocupado = 0.
//     tecla_leida is ignored while ocupado == 0, including during the LOAD cycle.
//     Holding tecla_leida high yields a single rtecla.
//   - The acknowledge is independent of the FSM: it may arrive in WAIT_REL, REL_DEB
//     or IDLE. A new press leaves IDLE only once ocupado == 0.
//   - Simultaneous events:
//     - loadN and rtecla can never be high in the same cycle.
//     - A press pending in IDLE while ocupado clears is accepted the cycle after
//       ocupado falls.
//   - Counter: cnt saturates logic-wise at DEB_CYCLES-1 and never wraps.
//     DEB_CYCLES = 1 means one stable sample is sufficient.
//   - Reset (at any point, including mid-debounce or with ocupado set):
//     - state = IDLE; cnt, snap, sel and synchroniser flops = 0;
//     - load1..load4 = 0, rtecla = 0, ocupado = 0 in the cycle after reset is sampled;
//     - a key held through reset is treated as a new press once reset falls.
// TESTING  (DEB_CYCLES = 4)
//   1. Raise teclas = 4'b0100 and hold it: load3 is high for exactly 1 cycle,
//      7 posedges after the edge; ocupado rises the next cycle; no further loads.
//   2. Pulse teclas = 4'b0001 for 3 cycles (shorter than debounce):
//      no load pulse; FSM returns to IDLE.
//   3. teclas = 4'b1010: only load2 pulses.
//      Then tecla_leida = 1 for 5 cycles: a single rtecla pulse; ocupado goes 1->0.
//   4. Press key 1, release, press key 4 without tecla_leida:
//      no load4 until tecla_leida; load4 follows the ack per the debounce timing.
//   5. Key released with 2-cycle bounces inside REL_DEB: FSM returns to WAIT_REL;
//      IDLE is reached only after 4 clean zero cycles.
//   6. Assert reset during DEBOUNCE and again with ocupado = 1:
//      all outputs 0 the next cycle; a key held through reset gives a fresh load.

Source files
------------

// File: rtl/control_teclado.sv
// control_teclado: synchronises and debounces the keypad lines, issues one load pulse per press and the rtecla clear on acknowledge
module control_teclado #(
  parameter int DEB_CYCLES = 500000,
  parameter int CNT_W      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] teclas,
  input  logic       tecla_leida,
  output logic       load1,
  output logic       load2,
  output logic       load3,
  output logic       load4,
  output logic       rtecla,
  output logic       ocupado
);
  typedef enum logic [2:0] {IDLE, DEBOUNCE, LOAD, WAIT_REL, REL_DEB} state_t;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] meta_q, key_sync_q, snap_q, snap_d, sel_q, sel_d, load;
  logic ocupado_q, ocupado_d, rtecla_q, rtecla_d;
  // synchroniser, FSM state, debounce bookkeeping and handshake flags
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q     <= '0;
      key_sync_q <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      snap_q     <= '0;
      sel_q      <= '0;
      ocupado_q  <= 1'b0;
      rtecla_q   <= 1'b0;
    end else begin
      meta_q     <= teclas;
      key_sync_q <= meta_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      sel_q      <= sel_d;
      ocupado_q  <= ocupado_d;
      rtecla_q   <= rtecla_d;
    end
  end
  // next state: debounce the press, fire one load, then debounce the release
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    snap_d  = snap_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: if (key_sync_q != '0 && !ocupado_q) begin
        state_d = DEBOUNCE;
        snap_d  = key_sync_q;
        sel_d   = key_sync_q & (~key_sync_q + 4'd1);
        cnt_d   = '0;
      end
      DEBOUNCE: if (key_sync_q != snap_q) state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = LOAD;
        else cnt_d = cnt_q + 1'b1;
      LOAD: state_d = WAIT_REL;
      WAIT_REL: if (key_sync_q == '0) begin
        state_d = REL_DEB;
        cnt_d   = '0;
      end
      REL_DEB: if (key_sync_q != '0) state_d = WAIT_REL;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
        else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  // outputs: one-hot load in LOAD; acknowledge clears ocupado and pulses rtecla once
  always_comb begin
    load      = (state_q == LOAD) ? sel_q : 4'd0;
    ocupado_d = (state_q == LOAD) | (ocupado_q & ~tecla_leida);
    rtecla_d  = ocupado_q & tecla_leida;
  end
  assign load1   = load[0];
  assign load2   = load[1];
  assign load3   = load[2];
  assign load4   = load[3];
  assign rtecla  = rtecla_q;
  assign ocupado = ocupado_q;
endmodule
